// File: rtl/video_sig_pkg.sv
// ---------------------------------------------------------------------------
// video_sig_pkg
// Shared definitions for the frame signature block:
//   sig_state_t  - capture state machine encoding (IDLE, ARMED, CAPTURE)
//   CRC32_POLY   - CRC-32/MPEG-2 polynomial
//   CRC32_INIT   - CRC seed loaded at the start of each frame
//   CRC_MAX_W    - widest data word crc32_next can absorb
//   crc32_next   - advance a CRC over the low w bits of a word, MSB first
// ---------------------------------------------------------------------------
package video_sig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } sig_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam int          CRC_MAX_W  = 64;

    // The loop bound is a constant so this unrolls into a fixed XOR network;
    // bits at or above w are skipped, so callers zero-extend narrower words.
    function automatic logic [31:0] crc32_next(
        input logic [31:0]          crc,
        input logic [CRC_MAX_W-1:0] data,
        input int                   w
    );
        logic [31:0] c;
        c = crc;
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                if (c[31] ^ data[i]) begin
                    c = {c[30:0], 1'b0} ^ CRC32_POLY;
                end else begin
                    c = {c[30:0], 1'b0};
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_step.sv
// ---------------------------------------------------------------------------
// crc32_step
// Combinational single-word CRC-32/MPEG-2 update.
// Ports:
//   crc_in  - current CRC value
//   data    - W-bit word, consumed MSB first
//   crc_out - CRC after absorbing data
// ---------------------------------------------------------------------------
module crc32_step
    import video_sig_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [31:0]  crc_in,
    input  logic [W-1:0] data,
    output logic [31:0]  crc_out
);

    logic [CRC_MAX_W-1:0] data_ext;

    always_comb begin
        data_ext         = '0;
        data_ext[W-1:0]  = data;
        crc_out          = crc32_next(crc_in, data_ext, W);
    end

endmodule

// File: rtl/video_frame_signature.sv
// ---------------------------------------------------------------------------
// video_frame_signature
// Computes a CRC-32/MPEG-2 signature over a rectangular region of interest
// of each video frame, for one or more consecutive frames, and presents each
// result through a single valid/ready holding register.
// Ports:
//   Clk, reset_rtl_0         - clock, asynchronous active-low reset
//   pixel_ce                 - pixel strobe; video inputs sampled only here
//   vs, active_nblank        - vertical sync (active low), active region
//   drawX, drawY, pixel      - current coordinate and pixel word
//   roi_x0/y0/x1/y1          - inclusive region bounds
//   start, num_frames, abort - run control
//   sig_valid/ready/data     - result handshake and frame CRC
//   sig_frame_idx            - frame index within the run
//   sig_pix_count            - pixels hashed in that frame
//   busy, overflow           - run in progress, result dropped (sticky)
// ---------------------------------------------------------------------------
module video_frame_signature
    import video_sig_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int BPC      = 4,
    parameter int COORD_W  = 10,
    parameter int FRAMES_W = 8
) (
    input  logic                    Clk,
    input  logic                    reset_rtl_0,
    input  logic                    pixel_ce,
    input  logic                    vs,
    input  logic                    active_nblank,
    input  logic [COORD_W-1:0]      drawX,
    input  logic [COORD_W-1:0]      drawY,
    input  logic [CHANNELS*BPC-1:0] pixel,
    input  logic [COORD_W-1:0]      roi_x0,
    input  logic [COORD_W-1:0]      roi_y0,
    input  logic [COORD_W-1:0]      roi_x1,
    input  logic [COORD_W-1:0]      roi_y1,
    input  logic                    start,
    input  logic [FRAMES_W-1:0]     num_frames,
    input  logic                    abort,
    output logic                    sig_valid,
    input  logic                    sig_ready,
    output logic [31:0]             sig_data,
    output logic [FRAMES_W-1:0]     sig_frame_idx,
    output logic [2*COORD_W-1:0]    sig_pix_count,
    output logic                    busy,
    output logic                    overflow
);

    localparam int W = CHANNELS * BPC;
    localparam logic [2*COORD_W-1:0] CNT_ONE   = 1;
    localparam logic [FRAMES_W-1:0]  FRAME_ONE = 1;

    sig_state_t             state;
    logic                   vs_prev;
    logic [31:0]            crc;
    logic [2*COORD_W-1:0]   pix_count;
    logic [FRAMES_W-1:0]    frame_idx;
    logic [FRAMES_W-1:0]    frames_left;

    logic                   in_roi;
    logic                   hash_pixel;
    logic                   boundary;
    logic                   emit;
    logic [31:0]            crc_src;
    logic [31:0]            crc_hashed;

    assign in_roi     = (drawX >= roi_x0) && (drawX <= roi_x1) &&
                        (drawY >= roi_y0) && (drawY <= roi_y1);
    assign hash_pixel = pixel_ce && active_nblank && in_roi;
    assign boundary   = pixel_ce && vs_prev && !vs;
    assign emit       = (state == CAPTURE) && boundary && !abort;

    // A pixel arriving together with a boundary starts the next frame, so it
    // is hashed on top of the seed rather than the running CRC.
    assign crc_src = ((state == CAPTURE) && !boundary) ? crc : CRC32_INIT;

    crc32_step #(.W(W)) u_crc_step (
        .crc_in  (crc_src),
        .data    (pixel),
        .crc_out (crc_hashed)
    );

    // vsync history advances only on pixel strobes, so the edge detect runs
    // in the pixel clock domain even though Clk is faster.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            vs_prev <= 1'b1;
        end else if (pixel_ce) begin
            vs_prev <= vs;
        end
    end

    // Capture state machine together with the result holding register.
    // The holding register is served independently of abort so a pending
    // result survives an aborted run.
    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state         <= IDLE;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            crc           <= '0;
            pix_count     <= '0;
            frame_idx     <= '0;
            frames_left   <= '0;
            sig_valid     <= 1'b0;
            sig_data      <= '0;
            sig_frame_idx <= '0;
            sig_pix_count <= '0;
        end else begin
            if (sig_valid && sig_ready) begin
                sig_valid <= 1'b0;
            end

            if (emit) begin
                if (!sig_valid || sig_ready) begin
                    sig_valid     <= 1'b1;
                    sig_data      <= crc;
                    sig_frame_idx <= frame_idx;
                    sig_pix_count <= pix_count;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (abort) begin
                state       <= IDLE;
                busy        <= 1'b0;
                crc         <= '0;
                pix_count   <= '0;
                frame_idx   <= '0;
                frames_left <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            frames_left <= (num_frames == '0) ? FRAME_ONE : num_frames;
                            overflow    <= 1'b0;
                            state       <= ARMED;
                            busy        <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (boundary) begin
                            state     <= CAPTURE;
                            frame_idx <= '0;
                            crc       <= hash_pixel ? crc_hashed : CRC32_INIT;
                            pix_count <= hash_pixel ? CNT_ONE : '0;
                        end
                    end
                    CAPTURE: begin
                        if (boundary) begin
                            frames_left <= frames_left - FRAME_ONE;
                            frame_idx   <= frame_idx + FRAME_ONE;
                            crc         <= hash_pixel ? crc_hashed : CRC32_INIT;
                            pix_count   <= hash_pixel ? CNT_ONE : '0;
                            if (frames_left <= FRAME_ONE) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (hash_pixel) begin
                            crc       <= crc_hashed;
                            pix_count <= pix_count + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_frame_signature.sv
// ---------------------------------------------------------------------------
// tb_video_frame_signature
// Randomized bench for video_frame_signature. A scaled-down raster generator
// drives frames from a pixel memory; expected signatures are computed from
// that memory by a frame-level CRC model. A second instance with 8-bit
// pixels checks the CRC-32/MPEG-2 check value over "123456789".
// ---------------------------------------------------------------------------
module tb_video_frame_signature;

    localparam int H_TOTAL  = 36;
    localparam int H_ACTIVE = 32;
    localparam int V_TOTAL  = 34;
    localparam int V_ACTIVE = 30;
    localparam int V_SYNC   = 2;
    localparam int V_OFF    = 4;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct {
        logic [31:0] crc;
        logic [7:0]  idx;
        logic [19:0] cnt;
    } result_t;

    logic        Clk = 1'b0;
    logic        reset_rtl_0;
    logic        pixel_ce;
    logic        vs;
    logic        active_nblank;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic [11:0] pixel;
    logic [7:0]  pixel8;
    logic [9:0]  roi_x0, roi_y0, roi_x1, roi_y1;
    logic        start;
    logic [7:0]  num_frames;
    logic        abort;
    logic        sig_ready;

    logic        sig_valid, busy, overflow;
    logic [31:0] sig_data;
    logic [7:0]  sig_frame_idx;
    logic [19:0] sig_pix_count;

    logic        sig_valid8, busy8, overflow8;
    logic [31:0] sig_data8;
    logic [7:0]  sig_frame_idx8;
    logic [19:0] sig_pix_count8;

    logic [11:0] mem [4][V_ACTIVE][H_ACTIVE];
    result_t     gotQ[$];
    result_t     got8Q[$];

    int vectors    = 0;
    int miscompares = 0;

    assign pixel8 = pixel[7:0];

    always #5 Clk = ~Clk;

    video_frame_signature dut (
        .Clk(Clk), .reset_rtl_0(reset_rtl_0), .pixel_ce(pixel_ce), .vs(vs),
        .active_nblank(active_nblank), .drawX(drawX), .drawY(drawY), .pixel(pixel),
        .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_x1(roi_x1), .roi_y1(roi_y1),
        .start(start), .num_frames(num_frames), .abort(abort),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_data(sig_data),
        .sig_frame_idx(sig_frame_idx), .sig_pix_count(sig_pix_count),
        .busy(busy), .overflow(overflow)
    );

    video_frame_signature #(.CHANNELS(1), .BPC(8)) dut8 (
        .Clk(Clk), .reset_rtl_0(reset_rtl_0), .pixel_ce(pixel_ce), .vs(vs),
        .active_nblank(active_nblank), .drawX(drawX), .drawY(drawY), .pixel(pixel8),
        .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_x1(roi_x1), .roi_y1(roi_y1),
        .start(start), .num_frames(num_frames), .abort(abort),
        .sig_valid(sig_valid8), .sig_ready(sig_ready), .sig_data(sig_data8),
        .sig_frame_idx(sig_frame_idx8), .sig_pix_count(sig_pix_count8),
        .busy(busy8), .overflow(overflow8)
    );

    // Log every completed transfer; inputs change just after posedge, so the
    // negedge view matches what the next posedge will accept.
    always @(negedge Clk) begin
        if (sig_valid && sig_ready) begin
            gotQ.push_back('{sig_data, sig_frame_idx, sig_pix_count});
        end
        if (sig_valid8 && sig_ready) begin
            got8Q.push_back('{sig_data8, sig_frame_idx8, sig_pix_count8});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Frame-level reference: raster-order walk of the region, each word
    // shifted into the CRC most significant bit first.
    task automatic modelFrame(input int p, input int x0, input int y0,
                              input int x1, input int y1,
                              output logic [31:0] crc, output int cnt);
        logic fb;
        crc = 32'hFFFFFFFF;
        cnt = 0;
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++) begin
                if (x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
                    cnt++;
                    for (int b = 11; b >= 0; b--) begin
                        fb  = crc[31] ^ mem[p][y][x][b];
                        crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic vsv, input logic act,
                                 input int x, input int y, input logic [11:0] p);
        pixel_ce      = ce;
        vs            = vsv;
        active_nblank = act;
        drawX         = 10'(x);
        drawY         = 10'(y);
        pixel         = p;
        @(posedge Clk);
        #1;
    endtask

    // One pixel strobe, sometimes preceded by an idle cycle carrying junk.
    task automatic pixelAt(input logic vsv, input logic act, input int x,
                           input int y, input logic [11:0] p);
        if ($urandom_range(0, 3) == 0) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom_range(0, 40),
                          $urandom_range(0, 40), 12'($urandom));
        end
        applyStimulus(1'b1, vsv, act, x, y, p);
    endtask

    task automatic idle(input int n);
        pixel_ce = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Each period opens with the vsync fall, then blanking, then active rows.
    task automatic runPeriods(input int n);
        int yy;
        logic act;
        for (int f = 0; f < n; f++) begin
            for (int line = 0; line < V_TOTAL; line++) begin
                yy = (line < V_OFF) ? V_ACTIVE + line : line - V_OFF;
                for (int x = 0; x < H_TOTAL; x++) begin
                    act = (line >= V_OFF) && (x < H_ACTIVE);
                    pixelAt(line >= V_SYNC, act, x, yy,
                            act ? mem[f][yy][x] : 12'($urandom));
                end
            end
        end
    endtask

    task automatic syncPulse();
        for (int i = 0; i < 4; i++) pixelAt(1'b0, 1'b0, i, V_ACTIVE, 12'($urandom));
        for (int i = 4; i < 12; i++) pixelAt(1'b1, 1'b0, i, V_ACTIVE, 12'($urandom));
        idle(4);
    endtask

    task automatic fillRandom(input int p);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++)
                mem[p][y][x] = 12'($urandom);
    endtask

    task automatic startRun(input int x0, input int y0, input int x1, input int y1,
                            input int nf);
        roi_x0 = 10'(x0);
        roi_y0 = 10'(y0);
        roi_x1 = 10'(x1);
        roi_y1 = 10'(y1);
        num_frames = 8'(nf);
        pixel_ce = 1'b0;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseAbort();
        pixel_ce = 1'b0;
        abort = 1'b1;
        @(posedge Clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int nExp, input int x0,
                            input int y0, input int x1, input int y1);
        logic [31:0] eCrc;
        int eCnt;
        checkOutput({tag, "_results"}, 64'(gotQ.size()), 64'(nExp));
        for (int i = 0; i < nExp && i < gotQ.size(); i++) begin
            modelFrame(i, x0, y0, x1, y1, eCrc, eCnt);
            checkOutput($sformatf("%s_crc%0d", tag, i), 64'(gotQ[i].crc), 64'(eCrc));
            checkOutput($sformatf("%s_idx%0d", tag, i), 64'(gotQ[i].idx), 64'(i));
            checkOutput($sformatf("%s_cnt%0d", tag, i), 64'(gotQ[i].cnt), 64'(eCnt));
        end
        gotQ.delete();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] refA;
        int refCnt;
        int x0, y0, x1, y1, nf, n;

        reset_rtl_0 = 1'b0;
        pixel_ce = 1'b0; vs = 1'b1; active_nblank = 1'b0;
        drawX = '0; drawY = '0; pixel = '0;
        roi_x0 = '0; roi_y0 = '0; roi_x1 = '0; roi_y1 = '0;
        start = 1'b0; num_frames = '0; abort = 1'b0; sig_ready = 1'b1;

        #23;
        @(posedge Clk);
        #1;
        reset_rtl_0 = 1'b1;
        idle(2);
        checkOutput("rst_valid", 64'(sig_valid), 64'(0));
        checkOutput("rst_data", 64'(sig_data), 64'(0));
        checkOutput("rst_idx", 64'(sig_frame_idx), 64'(0));
        checkOutput("rst_cnt", 64'(sig_pix_count), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_ovf", 64'(overflow), 64'(0));

        // Check value: "123456789" on the first active row.
        fillRandom(0);
        for (int i = 0; i < 9; i++) mem[0][0][i] = 12'(8'h31 + i);
        startRun(0, 0, 8, 0, 1);
        runPeriods(1);
        checkOutput("kat_busy_before", 64'(busy), 64'(1));
        syncPulse();
        checkOutput("kat_busy_after", 64'(busy), 64'(0));
        checkOutput("kat8_results", 64'(got8Q.size()), 64'(1));
        if (got8Q.size() > 0) begin
            checkOutput("kat8_crc", 64'(got8Q[0].crc), 64'h0376E6E7);
            checkOutput("kat8_cnt", 64'(got8Q[0].cnt), 64'(9));
            checkOutput("kat8_idx", 64'(got8Q[0].idx), 64'(0));
        end
        checkRun("kat12", 1, 0, 0, 8, 0);

        // ROI clipping, then outside pixels changed.
        fillRandom(0);
        modelFrame(0, 10, 20, 19, 29, refA, refCnt);
        startRun(10, 20, 19, 29, 1);
        runPeriods(1);
        syncPulse();
        if (gotQ.size() > 0) checkOutput("roi_cnt100", 64'(gotQ[0].cnt), 64'(100));
        checkRun("roi", 1, 10, 20, 19, 29);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++)
                if (!(x >= 10 && x <= 19 && y >= 20 && y <= 29)) mem[0][y][x] = 12'($urandom);
        startRun(10, 20, 19, 29, 1);
        runPeriods(1);
        syncPulse();
        if (gotQ.size() > 0) checkOutput("roi_outside", 64'(gotQ[0].crc), 64'(refA));
        checkRun("roi2", 1, 10, 20, 19, 29);

        // Three identical frames.
        fillRandom(0);
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++) begin
                mem[1][y][x] = mem[0][y][x];
                mem[2][y][x] = mem[0][y][x];
            end
        startRun(0, 0, 35, 33, 3);
        runPeriods(3);
        syncPulse();
        checkOutput("multi_ovf", 64'(overflow), 64'(0));
        checkRun("multi", 3, 0, 0, 35, 33);

        // Backpressure: frame 0 held, frame 1 dropped.
        fillRandom(0);
        fillRandom(1);
        sig_ready = 1'b0;
        startRun(3, 2, 25, 27, 2);
        runPeriods(2);
        syncPulse();
        modelFrame(0, 3, 2, 25, 27, refA, refCnt);
        checkOutput("bp_valid", 64'(sig_valid), 64'(1));
        checkOutput("bp_data", 64'(sig_data), 64'(refA));
        checkOutput("bp_idx", 64'(sig_frame_idx), 64'(0));
        checkOutput("bp_cnt", 64'(sig_pix_count), 64'(refCnt));
        checkOutput("bp_ovf", 64'(overflow), 64'(1));
        checkOutput("bp_busy", 64'(busy), 64'(0));
        startRun(3, 2, 25, 27, 1);
        checkOutput("bp_ovf_cleared", 64'(overflow), 64'(0));
        pulseAbort();
        checkOutput("bp_held_after_abort", 64'(sig_data), 64'(refA));
        sig_ready = 1'b1;
        idle(3);
        checkRun("bp_drain", 1, 3, 2, 25, 27);
        checkOutput("bp_valid_drained", 64'(sig_valid), 64'(0));

        // Abort mid-capture, and start together with abort.
        fillRandom(0);
        startRun(0, 0, 31, 29, 1);
        runPeriods(1);
        pulseAbort();
        checkOutput("abort_busy", 64'(busy), 64'(0));
        syncPulse();
        checkOutput("abort_no_emit", 64'(gotQ.size()), 64'(0));
        start = 1'b1;
        pulseAbort();
        start = 1'b0;
        checkOutput("start_abort_busy", 64'(busy), 64'(0));

        // Asynchronous reset mid-run with a held result.
        fillRandom(0);
        fillRandom(1);
        sig_ready = 1'b0;
        startRun(0, 0, 31, 29, 2);
        runPeriods(2);
        checkOutput("rstmid_pre_valid", 64'(sig_valid), 64'(1));
        #2;
        reset_rtl_0 = 1'b0;
        #1;
        checkOutput("rstmid_valid", 64'(sig_valid), 64'(0));
        checkOutput("rstmid_data", 64'(sig_data), 64'(0));
        checkOutput("rstmid_idx", 64'(sig_frame_idx), 64'(0));
        checkOutput("rstmid_cnt", 64'(sig_pix_count), 64'(0));
        checkOutput("rstmid_busy", 64'(busy), 64'(0));
        checkOutput("rstmid_ovf", 64'(overflow), 64'(0));
        @(posedge Clk);
        #1;
        reset_rtl_0 = 1'b1;
        sig_ready = 1'b1;
        vs = 1'b1;
        idle(2);
        syncPulse();
        checkOutput("rstmid_no_emit", 64'(gotQ.size()), 64'(0));
        checkOutput("rstmid_busy_after", 64'(busy), 64'(0));

        // Empty ROI.
        fillRandom(0);
        startRun(5, 0, 4, 29, 1);
        runPeriods(1);
        syncPulse();
        if (gotQ.size() > 0) begin
            checkOutput("empty_crc", 64'(gotQ[0].crc), 64'hFFFFFFFF);
            checkOutput("empty_cnt", 64'(gotQ[0].cnt), 64'(0));
        end
        checkRun("empty", 1, 5, 0, 4, 29);

        // Random regions and frame counts (0 means one frame).
        for (int t = 0; t < 4; t++) begin
            x0 = $urandom_range(0, 35);
            x1 = $urandom_range(0, 35);
            y0 = $urandom_range(0, 33);
            y1 = $urandom_range(0, 33);
            nf = $urandom_range(0, 2);
            n  = (nf == 0) ? 1 : nf;
            for (int p = 0; p < n; p++) fillRandom(p);
            startRun(x0, y0, x1, y1, nf);
            runPeriods(n);
            syncPulse();
            checkRun($sformatf("rand%0d", t), n, x0, y0, x1, y1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
